// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants, request op codes and loader FSM states
// for the nano_rv32i program loader.
package rv_pkg;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;

    typedef enum logic [2:0] {
        OP_ADDI = 3'd0,
        OP_BEQ  = 3'd1,
        OP_JAL  = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_BAD_OP  = 2'b01;
    localparam logic [1:0] ERR_BAD_IMM = 2'b10;
endpackage

// File: rtl/instr_fields_enc.sv
// Combinational RV32I field packer: turns a symbolic request into a 32-bit
// instruction word and flags unknown ops or out-of-range immediates.
module instr_fields_enc
    import rv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        bad_op,
    output logic        bad_imm
);
    logic signed [20:0] imm_s;
    logic               fits_i;
    logic               fits_b;

    assign imm_s  = $signed(imm);
    assign fits_i = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
    // Branch offsets are halfword-granular, so an odd byte offset is unencodable.
    assign fits_b = (imm_s >= -21'sd4096) && (imm_s <= 21'sd4094) && !imm[0];

    always_comb begin
        word    = '0;
        bad_op  = 1'b0;
        bad_imm = 1'b0;
        case (op)
            OP_ADDI: begin
                word    = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
                bad_imm = !fits_i;
            end
            OP_LW: begin
                word    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
                bad_imm = !fits_i;
            end
            OP_SW: begin
                word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
                bad_imm = !fits_i;
            end
            OP_BEQ: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                bad_imm = !fits_b;
            end
            OP_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                bad_imm = imm[0];
            end
            default: bad_op = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic requests, encodes them and streams the
// words into consecutive instruction-memory locations through a one-deep output register.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    finish_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [2:0]              op_i,
    input  logic [4:0]              rd_i,
    input  logic [4:0]              rs1_i,
    input  logic [4:0]              rs2_i,
    input  logic [20:0]             imm_i,
    output logic                    imem_we_o,
    output logic [ADDR_W-1:0]       imem_addr_o,
    output logic [31:0]             imem_wdata_o,
    input  logic                    imem_ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [1:0]              err_code_o
);
    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

    state_e            state_reg, state_next;
    logic              we_reg, we_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              err_reg, err_next;
    logic [1:0]        err_code_reg, err_code_next;

    logic [31:0]       enc_word;
    logic              enc_bad_op;
    logic              enc_bad_imm;
    logic [CNT_W:0]    occupancy;
    logic              write_done;
    logic              accept;

    instr_fields_enc u_fields (
        .op      (op_i),
        .rd      (rd_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .imm     (imm_i),
        .word    (enc_word),
        .bad_op  (enc_bad_op),
        .bad_imm (enc_bad_imm)
    );

    // Words committed plus the one waiting in the output register.
    assign occupancy   = {1'b0, count_reg} + {{CNT_W{1'b0}}, we_reg};
    assign write_done  = we_reg && imem_ready_i;
    assign req_ready_o = (state_reg == ST_LOAD) && (!we_reg || imem_ready_i)
                         && (occupancy < DEPTH_OCC);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_next    = state_reg;
        we_next       = we_reg;
        wdata_next    = wdata_reg;
        count_next    = count_reg + {{(CNT_W-1){1'b0}}, write_done};
        err_next      = err_reg;
        err_code_next = err_code_reg;

        if (write_done) begin
            we_next = 1'b0;
        end
        if (accept) begin
            if (!enc_bad_op && !enc_bad_imm) begin
                we_next    = 1'b1;
                wdata_next = enc_word;
            end else begin
                err_next = 1'b1;
                if (!err_reg) begin
                    err_code_next = enc_bad_op ? ERR_BAD_OP : ERR_BAD_IMM;
                end
            end
        end

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_next    = ST_LOAD;
                    count_next    = '0;
                    err_next      = 1'b0;
                    err_code_next = 2'b00;
                end
            end
            ST_LOAD: begin
                if (count_next == DEPTH_CNT) begin
                    state_next = ST_DONE;
                end else if (finish_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((count_next == DEPTH_CNT) || !we_next) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'b00;
        end else begin
            state_reg    <= state_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            count_reg    <= count_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    assign imem_we_o    = we_reg;
    assign imem_wdata_o = wdata_reg;
    assign imem_addr_o  = BASE_A + ADDR_W'({count_reg, 2'b00});
    assign count_o      = count_reg;
    assign busy_o       = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
    assign done_o       = (state_reg == ST_DONE);
    assign err_o        = err_reg;
    assign err_code_o   = err_code_reg;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder, checked against an
// arithmetic encoder and a queue-based session model.
module tb_instr_encoder;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 8;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_DONE = 3;

    logic              clk = 1'b0;
    logic              rst_i, start_i, finish_i, req_valid_i, imem_ready_i;
    logic              req_ready_o, imem_we_o, busy_o, done_o, err_o;
    logic [2:0]        op_i;
    logic [4:0]        rd_i, rs1_i, rs2_i;
    logic [20:0]       imm_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic [CNT_W-1:0]  count_o;
    logic [1:0]        err_code_o;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .finish_i(finish_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .op_i(op_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .imem_ready_i(imem_ready_i), .count_o(count_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_state, m_count, m_code;
    bit          m_err;
    logic [31:0] pend_q[$];
    logic [31:0] wr_data[$];
    int          wr_addr[$];
    int          corner_imm[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097, -4098, 1048574};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int fld(input int x, input int hi, input int lo);
        return (x >>> lo) & ((1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic int exp_addr(input int c);
        return (BASE_ADDR + 4 * c) % (1 << ADDR_W);
    endfunction

    // Instruction word assembled arithmetically from the ISA field layout.
    function automatic void ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                    input int imm, output logic [31:0] w, output bit bo, output bit bi);
        int r, a, b;
        r = rd & 31; a = rs1 & 31; b = rs2 & 31;
        w = 0; bo = 0; bi = 0;
        case (op)
            0, 3: begin
                w  = 32'((fld(imm, 11, 0) << 20) + (a << 15) + ((op == 3 ? 2 : 0) << 12)
                         + (r << 7) + (op == 3 ? 'h03 : 'h13));
                bi = (imm < -2048) || (imm > 2047);
            end
            4: begin
                w  = 32'((fld(imm, 11, 5) << 25) + (b << 20) + (a << 15) + (2 << 12)
                         + (fld(imm, 4, 0) << 7) + 'h23);
                bi = (imm < -2048) || (imm > 2047);
            end
            1: begin
                w  = 32'((fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (b << 20) | (a << 15)
                         | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 'h63);
                bi = (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
            end
            2: begin
                w  = 32'((fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                         | (fld(imm, 19, 12) << 12) | (r << 7) | 'h6F);
                bi = (imm & 1) != 0;
            end
            default: bo = 1;
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, advance the model.
    task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2,
                        input int imm, input bit mr, input bit st, input bit fin, output bit acc);
        bit          exp_ready, completed, bo, bi;
        logic [31:0] w;
        int          imm_s;
        req_valid_i = v; op_i = 3'(op); rd_i = 5'(rd); rs1_i = 5'(rs1); rs2_i = 5'(rs2);
        imm_i = 21'(imm); imem_ready_i = mr; start_i = st; finish_i = fin;
        #1;
        exp_ready = (m_state == M_LOAD) && (pend_q.size() == 0 || mr) && (m_count + pend_q.size() < DEPTH);
        check("req_ready", req_ready_o, exp_ready);
        check("we", imem_we_o, pend_q.size() != 0);
        check("count", count_o, m_count);
        check("busy", busy_o, (m_state == M_LOAD) || (m_state == M_DRAIN));
        check("done", done_o, m_state == M_DONE);
        check("err", err_o, m_err);
        check("err_code", err_code_o, m_code);
        if (pend_q.size() != 0) begin
            check("addr", imem_addr_o, exp_addr(m_count));
            check("wdata", imem_wdata_o, pend_q[0]);
        end
        completed = (pend_q.size() != 0) && mr;
        acc = v && exp_ready;
        if (completed) begin
            $display("write addr=%h data=%h", imem_addr_o, imem_wdata_o);
            wr_data.push_back(imem_wdata_o);
            wr_addr.push_back(int'(imem_addr_o));
            void'(pend_q.pop_front());
            m_count++;
        end
        if (acc) begin
            imm_s = int'($signed(imm_i));
            ref_enc(int'(op_i), rd, rs1, rs2, imm_s, w, bo, bi);
            if (!bo && !bi) pend_q.push_back(w);
            else begin
                if (!m_err) m_code = bo ? 1 : 2;
                m_err = 1;
            end
        end
        case (m_state)
            M_IDLE, M_DONE: if (st) begin m_state = M_LOAD; m_count = 0; m_err = 0; m_code = 0; end
            M_LOAD: begin
                if (m_count == DEPTH) m_state = M_DONE;
                else if (fin) m_state = M_DRAIN;
            end
            default: if (m_count == DEPTH || pend_q.size() == 0) m_state = M_DONE;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit mr, input bit st, input bit fin);
        bit acc;
        step(0, 0, 0, 0, 0, 0, mr, st, fin, acc);
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm, input bit fin);
        bit acc = 0;
        for (int i = 0; i < 16 && !acc; i++) step(1, op, rd, rs1, rs2, imm, 1, 0, fin, acc);
        check("send_accepted", acc, 1);
    endtask

    task automatic finish_session();
        idle(1, 0, 1);
        for (int i = 0; i < 16 && m_state != M_DONE; i++) idle(1, 0, 0);
        check("reach_done", done_o, 1);
    endtask

    task automatic do_reset();
        rst_i = 1; start_i = 0; finish_i = 0; req_valid_i = 0; imem_ready_i = 0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 0;
        m_state = M_IDLE; m_count = 0; m_err = 0; m_code = 0;
        pend_q.delete();
        #1;
        check("rst_we", imem_we_o, 0);
        check("rst_addr", imem_addr_o, BASE_ADDR);
        check("rst_wdata", imem_wdata_o, 0);
        check("rst_count", count_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_busy_done_err", {busy_o, done_o, err_o, err_code_o}, 0);
        @(negedge clk);
    endtask

    initial begin
        int n0, acc_n, imm, op;
        bit acc;
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        rst_i = 1; start_i = 0; finish_i = 0; req_valid_i = 0; imem_ready_i = 0;
        op_i = 0; rd_i = 0; rs1_i = 0; rs2_i = 0; imm_i = 0;
        @(negedge clk);
        do_reset();
        idle(1, 0, 0);

        // Basic ADDI / LW.
        n0 = wr_data.size();
        idle(1, 1, 0);
        send(0, 1, 0, 0, 5, 0);
        send(3, 5, 2, 0, -4, 0);
        finish_session();
        check("basic_w0", wr_data[n0], 32'h00500093);
        check("basic_a0", wr_addr[n0], BASE_ADDR);
        check("basic_w1", wr_data[n0+1], 32'hFFC12283);
        check("basic_a1", wr_addr[n0+1], BASE_ADDR + 4);
        check("basic_count", count_o, 2);

        // BEQ / JAL / SW; third address wraps past 2^ADDR_W.
        n0 = wr_data.size();
        idle(1, 1, 0);
        send(1, 0, 1, 2, 8, 0);
        send(2, 0, 0, 0, -4, 0);
        send(4, 0, 2, 5, 8, 0);
        finish_session();
        check("beq_word", wr_data[n0], 32'h00208463);
        check("jal_word", wr_data[n0+1], 32'hFFDFF06F);
        check("sw_word", wr_data[n0+2], 32'h00512423);
        check("wrap_addr", wr_addr[n0+2], 0);

        // Errors: rejected requests are consumed but not written.
        n0 = wr_data.size();
        idle(1, 1, 0);
        send(0, 1, 1, 0, 2048, 0);
        send(1, 0, 1, 2, 3, 0);
        send(5, 1, 1, 1, 0, 0);
        idle(1, 0, 0);
        check("err_nowrite", wr_data.size(), n0);
        check("err_flag", err_o, 1);
        check("err_first_code", err_code_o, 2'b10);
        send(0, 7, 7, 0, -2048, 0);
        finish_session();
        check("err_next_addr", wr_addr[n0], BASE_ADDR);
        idle(1, 1, 0);
        check("err_cleared", {err_o, err_code_o}, 0);
        send(6, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        check("bad_op_code", err_code_o, 2'b01);
        finish_session();

        // Backpressure for three cycles.
        n0 = wr_data.size();
        idle(1, 1, 0);
        send(0, 2, 3, 0, 100, 0);
        a0 = imem_addr_o; d0 = imem_wdata_o;
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 4, 5, 0, 16, 0, 0, 0, acc);
            check("bp_no_accept", acc, 0);
            check("bp_addr_stable", imem_addr_o, a0);
            check("bp_data_stable", imem_wdata_o, d0);
        end
        step(1, 3, 4, 5, 0, 16, 1, 0, 0, acc);
        check("bp_completed", wr_data.size(), n0 + 1);
        check("bp_data", wr_data[n0], d0);
        finish_session();
        check("bp_total", wr_data.size(), n0 + 2);

        // Fill to DEPTH with a continuous stream.
        idle(1, 1, 0);
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, i, i + 1, 0, i * 3, 1, 0, 0, acc);
            acc_n += int'(acc);
        end
        check("full_accepts", acc_n, DEPTH);
        check("full_done", done_o, 1);
        check("full_count", count_o, DEPTH);
        idle(1, 1, 0);
        check("restart_count", count_o, 0);

        // finish together with an accepted request.
        n0 = wr_data.size();
        step(1, 2, 3, 0, 0, 64, 1, 0, 1, acc);
        check("fin_accept", acc, 1);
        for (int i = 0; i < 16 && m_state != M_DONE; i++) idle(1, 0, 0);
        check("fin_written", wr_data.size(), n0 + 1);
        check("fin_done", done_o, 1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: imm = int'($urandom_range(0, 4095)) - 2048;
                1: imm = int'($urandom_range(0, 8191)) - 4096;
                2: imm = int'($urandom_range(0, 2097151)) - 1048576;
                default: imm = corner_imm[$urandom_range(0, 9)];
            endcase
            op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            step($urandom_range(0, 3) != 0, op, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), imm, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, acc);
        end

        // Reset while a write is stalled.
        for (int i = 0; i < 16 && m_state != M_DONE && m_state != M_IDLE; i++) idle(1, 0, 1);
        idle(1, 1, 0);
        send(0, 9, 9, 0, 9, 0);
        idle(0, 0, 0);
        check("pre_reset_we", imem_we_o, 1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader for the nano_rv32i core. It accepts symbolic instruction requests (ADDI, BEQ, JAL, LW, SW with register fields and a signed immediate) over a valid/ready handshake. It range-checks and encodes each request into the standard 32-bit RV32I word, then writes the words into consecutive instruction-memory locations. It is the producer of the words the core's instruction decoder consumes, and it is used to load test programs before the core is released from reset.

## Interface

Parameters:

- `ADDR_W`, 10: byte-address width of the instruction-memory write port.
- `DEPTH`, 256: maximum number of words written per load session.
- `BASE_ADDR`, 0: byte address of the first word; must be 4-aligned.

Ports:

- `clk_i`, in, 1: single clock; all logic is rising-edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: begin a load session.
- `finish_i`, in, 1: end the session after pending writes drain.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request ready.
- `op_i`, in, 3: 0 = ADDI, 1 = BEQ, 2 = JAL, 3 = LW, 4 = SW; values 5–7 are invalid.
- `rd_i`, `rs1_i`, `rs2_i`, in, 5 each: register fields; fields unused by the op are ignored.
- `imm_i`, in, 21: two's-complement immediate, in bytes for BEQ and JAL.
- `imem_we_o`, out, 1: write strobe (acts as the write-side valid).
- `imem_addr_o`, out, `ADDR_W`: byte address of the write.
- `imem_wdata_o`, out, 32: encoded instruction.
- `imem_ready_i`, in, 1: memory accepts the write this cycle.
- `count_o`, out, `$clog2(DEPTH)+1`: words written in the current session.
- `busy_o`, out, 1: high in LOAD or DRAIN.
- `done_o`, out, 1: high in DONE.
- `err_o`, out, 1: sticky error flag.
- `err_code_o`, out, 2: first error seen; 01 = bad op, 10 = bad immediate.

## Operation

- **FSM states:** IDLE, LOAD, DRAIN, DONE.
  - IDLE: on `start_i`, go to LOAD.
  - LOAD: on `finish_i`, go to DRAIN.
  - LOAD or DRAIN: when `count_o` reaches `DEPTH`, go to DONE.
  - DRAIN: when no write is pending, go to DONE.
  - DONE: on `start_i`, go to LOAD.
- **Session start:** entering LOAD clears `count_o`, `err_o` and `err_code_o`. `start_i` is ignored in LOAD and DRAIN.
- **Request acceptance:** a request is accepted on a cycle where `req_valid_i` and `req_ready_o` are both high.
  - `req_ready_o` = (state == LOAD) and (the output register is empty, or `imem_ready_i` is high) and (`count_o` + pending < `DEPTH`).
- **Encoding:**
  - ADDI: opcode 0010011, funct3 000, I-immediate.
  - LW: opcode 0000011, funct3 010, I-immediate.
  - SW: opcode 0100011, funct3 010, S-immediate split imm[11:5] / imm[4:0].
  - BEQ: opcode 1100011, funct3 000, B-immediate {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
  - JAL: opcode 1101111, J-immediate {imm[20], imm[10:1], imm[11], imm[19:12]}, rd.
- **Range checks:**
  - I and S formats: immediate within −2048..2047.
  - B format: within −4096..4094 and even.
  - J format: any 21-bit even value.
- **Failing requests:** a failing request is still handshaken (accepted) but is not written. `err_o` is set and stays set; `err_code_o` latches only the first error of the session.
- **Addressing:** `imem_addr_o` = `BASE_ADDR` + 4·`count_o`, taken modulo 2^`ADDR_W` (wraps silently).
- **Write completion:** `count_o` increments when `imem_we_o` and `imem_ready_i` are both high.
- **Simultaneous events:**
  - `finish_i` together with an accepted request: the request is written before DONE.
  - A write completing while a new request is accepted in the same cycle: the output register is refilled without a bubble.

## Timing

- **Reset values:**
  - State: IDLE.
  - Outputs: `imem_we_o` = 0, `imem_addr_o` = `BASE_ADDR`, `imem_wdata_o` = 0, `count_o` = 0, `req_ready_o` = 0, `busy_o` = 0, `done_o` = 0, `err_o` = 0, `err_code_o` = 00.
- **Latency:** a request accepted at edge N produces `imem_we_o` high, with valid address and data, from edge N+1.
- **Throughput:** one word per cycle when `imem_ready_i` is held high.
- **Backpressure:** while `imem_we_o` = 1 and `imem_ready_i` = 0, `imem_addr_o` and `imem_wdata_o` are held stable.
- **Status timing:** `done_o` rises the cycle after the last write completes. The error flags update the cycle after acceptance.
- **Reset mid-session:** the pending write is dropped and `imem_we_o` is 0 after the reset edge.

## Structure

- **Shared package `rv_pkg`:**
  - Opcode constants: OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_LOAD, OPC_STORE.
  - funct3 constants.
  - The `op_i` encoding.
  - The FSM state encoding.
- **Sub-module `instr_fields_enc`:** purely combinational; maps (op, rd, rs1, rs2, imm) to {word, bad_op, bad_imm}.
- **Top level:** the FSM, the output register, the counter and the error latch.

## Test plan

- **Basic encoding:** start; send ADDI rd=1, rs1=0, imm=5, then LW rd=5, rs1=2, imm=−4 → 0x00500093 written at `BASE_ADDR`, then 0xFFC12283 at `BASE_ADDR`+4; `count_o` = 2.
- **Branch, jump and store encoding:** BEQ rs1=1, rs2=2, imm=8 → 0x00208463; JAL rd=0, imm=−4 → 0xFFDFF06F; SW rs1=2, rs2=5, imm=8 → 0x00512423.
- **Error handling:** ADDI imm=2048, then BEQ imm=3 → neither is written; `err_o` = 1; `err_code_o` = 10; `count_o` unchanged; the next valid request is written at the next address.
- **Backpressure:** hold `imem_ready_i` low for 3 cycles during a write → address and data are stable and `req_ready_o` = 0; the write completes on the 4th cycle; no word is lost or duplicated.
- **Full and finish with `DEPTH` = 4:**
  - Stream 5 back-to-back requests → 4 words are written, the 5th is never accepted, and `done_o` = 1.
  - `start_i` then clears `count_o` to 0.
  - A separate session with `finish_i` asserted in the same cycle as an accepted request → that word is written, then DONE.
- **Reset mid-session:** assert `rst_i` while `imem_we_o` is held high → next cycle `imem_we_o` = 0 and all outputs are at their reset values.
